// File: rtl/trans_serializer.sv
// Buffers 128-bit transaction words in a small FIFO and streams them MSB-first as bytes over ready/valid.
// Define TRANS_SERIALIZER_FRAME_EN to wrap each word as 0xA5 header + 16 data bytes + XOR checksum.
module trans_serializer #(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [127:0]     data_i,
   input  logic             valid_i,
   output logic [7:0]       byte_o,
   output logic             byte_valid_o,
   input  logic             byte_ready_i,
   output logic [LVL_W-1:0] level_o,
   output logic             overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
`ifdef TRANS_SERIALIZER_FRAME_EN
   localparam logic [4:0] LAST_IDX = 5'd17;
`else
   localparam logic [4:0] LAST_IDX = 5'd15;
`endif

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [4:0]       idx;
   logic [127:0]     shreg;
   logic [127:0]     mem [DEPTH];
   logic [LVL_W-1:0] wr_ptr;
   logic [LVL_W-1:0] rd_ptr;
   logic [127:0]     rd_word;
   logic             hs;
   logic             pop;
   logic             push;
   logic             empty;
   logic             full;

`ifdef TRANS_SERIALIZER_FRAME_EN
   logic [7:0] chk;

   function automatic logic [7:0] xor_bytes(input logic [127:0] w);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 16; i++) r = r ^ w[8*i +: 8];
      return r;
   endfunction
`endif

   // Pointers carry one wrap bit, so their difference is the occupancy directly.
   assign level_o = wr_ptr - rd_ptr;

   always_comb begin
      hs      = byte_valid_o && byte_ready_i;
      empty   = (level_o == '0);
      full    = (level_o == LVL_W'(DEPTH));
      pop     = !empty && ((state == IDLE) || (hs && idx == LAST_IDX));
      push    = valid_i && (!full || pop);
      rd_word = mem[rd_ptr[PTR_W-1:0]];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= 5'd0;
         shreg        <= '0;
         byte_o       <= 8'h00;
         byte_valid_o <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         overflow_o   <= 1'b0;
`ifdef TRANS_SERIALIZER_FRAME_EN
         chk          <= 8'h00;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (valid_i && !push) overflow_o <= 1'b1;

         // A pop always reloads the shifter, covering both IDLE start and back-to-back words.
         if (pop) begin
            state        <= SEND;
            idx          <= 5'd0;
            byte_valid_o <= 1'b1;
`ifdef TRANS_SERIALIZER_FRAME_EN
            byte_o       <= 8'hA5;
            shreg        <= rd_word;
            chk          <= xor_bytes(rd_word);
`else
            byte_o       <= rd_word[127:120];
            shreg        <= {rd_word[119:0], 8'h00};
`endif
         end else if (hs) begin
            if (idx == LAST_IDX) begin
               state        <= IDLE;
               idx          <= 5'd0;
               byte_valid_o <= 1'b0;
            end else begin
               idx <= idx + 5'd1;
`ifdef TRANS_SERIALIZER_FRAME_EN
               if (idx == 5'd16) begin
                  byte_o <= chk;
               end else begin
                  byte_o <= shreg[127:120];
                  shreg  <= {shreg[119:0], 8'h00};
               end
`else
               byte_o <= shreg[127:120];
               shreg  <= {shreg[119:0], 8'h00};
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_trans_serializer.sv
// Directed bench for trans_serializer: queue-based byte-stream model compared every cycle plus literal checks.
module tb_trans_serializer;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef TRANS_SERIALIZER_FRAME_EN
   localparam int NB = 18;
   localparam logic [7:0] FIRST_B = 8'hA5;
   localparam logic [7:0] LAST_B  = 8'h00;
`else
   localparam int NB = 16;
   localparam logic [7:0] FIRST_B = 8'h01;
   localparam logic [7:0] LAST_B  = 8'h10;
`endif

   logic             clk;
   logic             rst_n = 1'b1;
   logic [127:0]     data_i;
   logic             valid_i;
   logic [7:0]       byte_o;
   logic             byte_valid_o;
   logic             byte_ready_i;
   logic [LVL_W-1:0] level_o;
   logic             overflow_o;

   trans_serializer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .level_o      (level_o),
      .overflow_o   (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [127:0] w, input int k);
      logic [7:0] x;
`ifdef TRANS_SERIALIZER_FRAME_EN
      if (k == 0) return 8'hA5;
      if (k == 17) begin
         x = 8'h00;
         for (int i = 0; i < 16; i++) x = x ^ w[8*i +: 8];
         return x;
      end
      return w[127 - 8*(k-1) -: 8];
`else
      x = w[127 - 8*k -: 8];
      return x;
`endif
   endfunction

   function automatic logic [127:0] word_n(input int n);
      return {4{32'hC0DE_0000 | 32'(n * 32'h0101_0001)}};
   endfunction

   // Model: FIFO contents as a queue, plus the word in flight and how many of its bytes remain.
   logic [127:0] mq[$];
   logic [127:0] cur;
   int           rem;
   logic         ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         cur = '0;
         rem = 0;
         ovf = 1'b0;
      end else begin
         automatic bit mhs  = (rem > 0) && byte_ready_i;
         automatic bit mpop = ((rem == 0) || (mhs && rem == 1)) && (mq.size() > 0);
         if (mhs) rem--;
         if (mpop) begin
            cur = mq.pop_front();
            rem = NB;
         end
         if (valid_i) begin
            if (mq.size() < DEPTH) mq.push_back(data_i);
            else ovf = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model, plus hold-during-stall check.
   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic [7:0] pb = 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         check("valid", 128'(byte_valid_o), 128'(rem > 0));
         if (rem > 0) check("byte", 128'(byte_o), 128'(exp_byte(cur, NB - rem)));
         check("level", 128'(level_o), 128'(mq.size()));
         check("overflow", 128'(overflow_o), 128'(ovf));
         if (pv && !pr) begin
            check("stall_valid", 128'(byte_valid_o), 128'(1'b1));
            check("stall_byte", 128'(byte_o), 128'(pb));
         end
         pv = byte_valid_o;
         pb = byte_o;
         pr = byte_ready_i;
      end else begin
         pv = 1'b0;
      end
   end

   logic [7:0] cap[$];
   int         capt[$];
   int         cyc = 0;

   always @(posedge clk) begin
      if (rst_n && byte_valid_o && byte_ready_i) begin
         cap.push_back(byte_o);
         capt.push_back(cyc);
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [127:0] w, input int gap);
      valid_i = 1'b1;
      data_i  = w;
      tick(1);
      valid_i = 1'b0;
      tick(gap);
   endtask

   localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] W2 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

   initial begin
      data_i       = '0;
      valid_i      = 1'b0;
      byte_ready_i = 1'b0;
      #1 rst_n = 1'b0;
      tick(2);
      check("rst_byte", 128'(byte_o), 128'h0);
      check("rst_valid", 128'(byte_valid_o), 128'h0);
      check("rst_level", 128'(level_o), 128'h0);
      check("rst_overflow", 128'(overflow_o), 128'h0);
      rst_n = 1'b1;
      tick(2);

      // Single word, ready held high
      cap.delete();
      byte_ready_i = 1'b1;
      valid_i = 1'b1;
      data_i  = W1;
      tick(1);
      valid_i = 1'b0;
      check("lat_level", 128'(level_o), 128'd1);
      check("lat_valid0", 128'(byte_valid_o), 128'd0);
      tick(1);
      check("lat_valid1", 128'(byte_valid_o), 128'd1);
      check("lat_byte0", 128'(byte_o), 128'(FIRST_B));
      tick(NB + 2);
      check("single_count", 128'(cap.size()), 128'(NB));
      if (cap.size() == NB) begin
         check("single_first", 128'(cap[0]), 128'(FIRST_B));
         check("single_last", 128'(cap[NB-1]), 128'(LAST_B));
`ifdef TRANS_SERIALIZER_FRAME_EN
         check("single_b1", 128'(cap[1]), 128'h01);
`else
         check("single_b1", 128'(cap[1]), 128'h23);
`endif
      end

      // Backpressure with ready toggling 1,0,0,1
      cap.delete();
      push_word(W2, 0);
      for (int i = 0; i < 80; i++) begin
         byte_ready_i = (i % 4 == 0) || (i % 4 == 3);
         tick(1);
      end
      byte_ready_i = 1'b1;
      tick(2);
      check("bp_count", 128'(cap.size()), 128'(NB));
      if (cap.size() == NB) begin
`ifdef TRANS_SERIALIZER_FRAME_EN
         check("bp_first", 128'(cap[1]), 128'h00);
         check("bp_chk", 128'(cap[17]), 128'h00);
`else
         check("bp_first", 128'(cap[0]), 128'h00);
         check("bp_last", 128'(cap[15]), 128'hFF);
`endif
         for (int k = 0; k < NB; k++) check("bp_order", 128'(cap[k]), 128'(exp_byte(W2, k)));
      end

      // Overflow under stall: 6 pulses, 5 held, 1 dropped
      byte_ready_i = 1'b0;
      cap.delete();
      for (int i = 1; i <= 6; i++) push_word(word_n(i), 4);
      check("ovf_level", 128'(level_o), 128'd4);
      check("ovf_flag", 128'(overflow_o), 128'd1);
      check("ovf_valid", 128'(byte_valid_o), 128'd1);
      byte_ready_i = 1'b1;
      tick(5 * NB + 10);
      check("ovf_drain_count", 128'(cap.size()), 128'(5 * NB));
      check("ovf_sticky", 128'(overflow_o), 128'd1);
      check("ovf_drain_level", 128'(level_o), 128'd0);
      if (cap.size() == 5 * NB) check("ovf_word5", 128'(cap[4*NB]), 128'(exp_byte(word_n(5), 0)));

      // Full FIFO with push on the same edge as a pop
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      byte_ready_i = 1'b0;
      tick(1);
      for (int i = 1; i <= 5; i++) push_word(word_n(10 + i), 4);
      check("full_level", 128'(level_o), 128'd4);
      byte_ready_i = 1'b1;
      tick(NB - 1);
      valid_i = 1'b1;
      data_i  = word_n(20);
      tick(1);
      valid_i = 1'b0;
      check("full_pushpop_level", 128'(level_o), 128'd4);
      check("full_pushpop_ovf", 128'(overflow_o), 128'd0);
      tick(5 * NB + 10);
      check("full_drained", 128'(level_o), 128'd0);

      // Back-to-back words 5 cycles apart
      cap.delete();
      capt.delete();
      push_word(W1, 4);
      push_word(W2, 2 * NB + 10);
      check("b2b_count", 128'(cap.size()), 128'(2 * NB));
      if (capt.size() == 2 * NB) check("b2b_span", 128'(capt[2*NB-1] - capt[0]), 128'(2 * NB - 1));

      // Reset mid-word with two words queued
      byte_ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) push_word(word_n(30 + i), 4);
      check("mid_level", 128'(level_o), 128'd2);
      byte_ready_i = 1'b1;
      tick(8);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 128'(byte_valid_o), 128'd0);
      check("mid_rst_byte", 128'(byte_o), 128'd0);
      check("mid_rst_level", 128'(level_o), 128'd0);
      tick(1);
      rst_n = 1'b1;
      cap.delete();
      tick(20);
      check("mid_quiet", 128'(cap.size()), 128'd0);
      check("mid_quiet_valid", 128'(byte_valid_o), 128'd0);
      push_word(W1, NB + 5);
      check("mid_after_count", 128'(cap.size()), 128'(NB));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
